lsu: RTL and testbench

- Multi-cycle load/store unit between the execute stage and writeback.
- Accepts one memory (or pass-through) operation per upstream handshake.
- Issues a single word-aligned request on a valid/ready data bus, waits for the response, then aligns and extends load data.
- Presents the result and exception code to writeback over a valid/ready handshake.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_align.sv | 47 ++++
 rtl/lsu.sv | 157 +++++++++++++++
 tb/tb_lsu.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit: FSM states, exception
// codes, RV32 funct3 widths and the base byte-strobe helper.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  localparam logic [2:0] EXC_NONE        = 3'd0;
  localparam logic [2:0] EXC_LD_MISALIGN = 3'd1;
  localparam logic [2:0] EXC_ST_MISALIGN = 3'd2;
  localparam logic [2:0] EXC_LD_BUS      = 3'd3;
  localparam logic [2:0] EXC_ST_BUS      = 3'd4;
  localparam logic [2:0] EXC_ILLEGAL     = 3'd5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Byte strobes for an access of the given size at lane 0.
  function automatic logic [3:0] base_strb(input logic [1:0] size);
    case (size)
      2'b00:   base_strb = 4'b0001;
      2'b01:   base_strb = 4'b0011;
      default: base_strb = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational access shaping: width legality, alignment, store lane
// placement and load extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        off,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [DATA_W-1:0] sdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              misalign,
  output logic              illegal,
  output logic [3:0]        wstrb,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ldata
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    illegal = (is_load && (funct3 == 3'b011 || funct3[2:1] == 2'b11)) ||
              (is_store && (funct3 >= 3'b011));
    misalign = (is_load || is_store) && !illegal &&
               ((funct3[1:0] == 2'b01 && off[0]) ||
                (funct3[1:0] == 2'b10 && off != 2'b00));
  end

  assign wstrb   = 4'(base_strb(funct3[1:0]) << off);
  assign wdata   = sdata << {off, 3'b000};
  assign shifted = rdata >> {off, 3'b000};

  // Extract the addressed lane and extend to the full register width.
  always_comb begin
    ldata = shifted;
    case (funct3)
      F3_LB:   ldata = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      F3_LH:   ldata = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      F3_LBU:  ldata = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      F3_LHU:  ldata = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      default: ldata = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Multi-cycle load/store unit: accepts one op, performs at most one bus
// transaction, and hands the aligned result and exception code to writeback.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [4:0]        in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_rd,
  output logic              out_wen,
  output logic [2:0]        out_exc,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_wen,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  output logic [3:0]        req_wstrb,
  input  logic              rsp_valid,
  output logic              rsp_ready,
  input  logic [DATA_W-1:0] rsp_rdata,
  input  logic              rsp_err
);

  state_t      state;
  logic        op_load;
  logic        op_store;
  logic [2:0]  op_funct3;
  logic [1:0]  op_off;

  logic        a_load;
  logic        a_store;
  logic [2:0]  a_funct3;
  logic [1:0]  a_off;
  logic        misalign;
  logic        illegal;
  logic [3:0]  sh_wstrb;
  logic [DATA_W-1:0] sh_wdata;
  logic [DATA_W-1:0] ldata;

  // The shaper sees the incoming op while idle and the latched op afterwards.
  always_comb begin
    a_load   = (state == IDLE) ? in_is_load  : op_load;
    a_store  = (state == IDLE) ? in_is_store : op_store;
    a_funct3 = (state == IDLE) ? in_funct3   : op_funct3;
    a_off    = (state == IDLE) ? in_addr[1:0] : op_off;
  end

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .funct3   (a_funct3),
    .off      (a_off),
    .is_load  (a_load),
    .is_store (a_store),
    .sdata    (in_data),
    .rdata    (rsp_rdata),
    .misalign (misalign),
    .illegal  (illegal),
    .wstrb    (sh_wstrb),
    .wdata    (sh_wdata),
    .ldata    (ldata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_load   <= 1'b0;
      op_store  <= 1'b0;
      op_funct3 <= 3'd0;
      op_off    <= 2'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_rd    <= 5'd0;
      out_wen   <= 1'b0;
      out_exc   <= EXC_NONE;
      req_valid <= 1'b0;
      req_wen   <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= 4'd0;
      rsp_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_load   <= in_is_load;
            op_store  <= in_is_store;
            op_funct3 <= in_funct3;
            op_off    <= in_addr[1:0];
            out_rd    <= in_rd;
            in_ready  <= 1'b0;
            if (illegal || misalign) begin
              out_data  <= '0;
              out_wen   <= 1'b0;
              out_exc   <= illegal ? EXC_ILLEGAL :
                           (in_is_load ? EXC_LD_MISALIGN : EXC_ST_MISALIGN);
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (!in_is_load && !in_is_store) begin
              out_data  <= in_data;
              out_wen   <= (in_rd != 5'd0);
              out_exc   <= EXC_NONE;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              req_valid <= 1'b1;
              req_wen   <= in_is_store;
              req_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
              req_wdata <= in_is_store ? sh_wdata : '0;
              req_wstrb <= in_is_store ? sh_wstrb : 4'd0;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            rsp_ready <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_valid) begin
            rsp_ready <= 1'b0;
            out_valid <= 1'b1;
            out_data  <= (op_load && !rsp_err) ? ldata : '0;
            out_wen   <= op_load && !rsp_err && (out_rd != 5'd0);
            out_exc   <= rsp_err ? (op_load ? EXC_LD_BUS : EXC_ST_BUS) : EXC_NONE;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_wen   <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: drives ops through the upstream, bus and writeback
// handshakes and compares against hand-computed results.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_is_load = 1'b0;
  logic        in_is_store = 1'b0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [31:0] in_addr = 32'd0;
  logic [31:0] in_data = 32'd0;
  logic [4:0]  in_rd = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [2:0]  out_exc;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid = 1'b0;
  logic        rsp_ready;
  logic [31:0] rsp_rdata = 32'd0;
  logic        rsp_err = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load),
    .in_is_store(in_is_store), .in_funct3(in_funct3), .in_addr(in_addr),
    .in_data(in_data), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_wen(out_wen), .out_exc(out_exc),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One op end to end; req_wait = cycles req_ready stays low, hold = cycles
  // out_ready stays low once the result is up, lat = edges from accept to DONE.
  task automatic do_op(input string tag, input logic ld, input logic st,
                       input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] data, input logic [4:0] rd,
                       input int req_wait, input logic [31:0] rdata, input logic err,
                       input logic exp_bus, input logic [31:0] exp_wdata,
                       input logic [3:0] exp_strb, input logic chk_data,
                       input logic [31:0] exp_out, input logic exp_wen,
                       input logic [2:0] exp_exc, input int exp_lat, input int hold);
    int edges;
    int nwait;
    logic saw_req;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_strb;
    logic        s_wen;
    edges = 0; nwait = 0; saw_req = 1'b0;
    s_addr = 32'd0; s_wdata = 32'd0; s_strb = 4'd0; s_wen = 1'b0;
    @(negedge clk);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
    in_addr = addr; in_data = data; in_rd = rd;
    @(posedge clk);
    edges = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0;
      if (out_valid) break;
      if (req_valid) begin
        if (!saw_req) begin
          saw_req = 1'b1;
          s_addr = req_addr; s_wdata = req_wdata; s_strb = req_wstrb; s_wen = req_wen;
          check({tag, ".req_addr"}, req_addr, {addr[31:2], 2'b00});
          check({tag, ".req_wen"}, 32'(req_wen), 32'(st));
          check({tag, ".req_wstrb"}, 32'(req_wstrb), 32'(exp_strb));
          if (st) check({tag, ".req_wdata"}, req_wdata, exp_wdata);
        end else begin
          check({tag, ".req_stable"},
                {s_addr ^ req_addr} | {s_wdata ^ req_wdata} | 32'({s_strb ^ req_wstrb}) | 32'(s_wen ^ req_wen),
                32'd0);
        end
        if (nwait >= req_wait) req_ready = 1'b1;
        else nwait++;
      end
      if (rsp_ready) begin
        rsp_valid = 1'b1; rsp_rdata = rdata; rsp_err = err;
      end
      @(posedge clk);
      edges++;
    end
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".bus_used"}, 32'(saw_req), 32'(exp_bus));
    check({tag, ".latency"}, 32'(edges), 32'(exp_lat));
    check({tag, ".out_exc"}, 32'(out_exc), 32'(exp_exc));
    check({tag, ".out_wen"}, 32'(out_wen), 32'(exp_wen));
    check({tag, ".out_rd"}, 32'(out_rd), 32'(rd));
    if (chk_data) check({tag, ".out_data"}, out_data, exp_out);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_exc"}, 32'(out_exc), 32'(exp_exc));
      check({tag, ".hold_wen"}, 32'(out_wen), 32'(exp_wen));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.req_valid", 32'(req_valid), 32'd0);
    check("rst.rsp_ready", 32'(rsp_ready), 32'd0);
    check("rst.out_wen", 32'(out_wen), 32'd0);
    check("rst.req_wen", 32'(req_wen), 32'd0);
    check("rst.req_wstrb", 32'(req_wstrb), 32'd0);
    check("rst.out_exc", 32'(out_exc), 32'd0);
    check("rst.out_data", out_data, 32'd0);
    check("rst.req_addr", req_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Stray response while idle must be ignored.
    @(negedge clk);
    rsp_valid = 1'b1; rsp_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    rsp_valid = 1'b0;
    check("stray.rsp_ready", 32'(rsp_ready), 32'd0);
    check("stray.out_valid", 32'(out_valid), 32'd0);
    check("stray.in_ready", 32'(in_ready), 32'd1);

    //      tag      ld    st    f3      addr          data          rd  rw rdata         err   bus   wdata         strb     cd    out           wen   exc   lat hold
    do_op("sw",     1'b0, 1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 7, 0, 32'h0,        1'b0, 1'b1, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0,        1'b0, 3'd0, 3, 0);
    do_op("lb",     1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0,         5, 0, 32'h8012_3456, 1'b0, 1'b1, 32'h0,        4'b0000, 1'b1, 32'hFFFF_FF80, 1'b1, 3'd0, 3, 0);
    do_op("lbu",    1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0,         5, 0, 32'h8012_3456, 1'b0, 1'b1, 32'h0,        4'b0000, 1'b1, 32'h0000_0080, 1'b1, 3'd0, 3, 0);
    do_op("sh",     1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 0, 0, 32'h0,        1'b0, 1'b1, 32'hABCD_0000, 4'b1100, 1'b0, 32'h0,        1'b0, 3'd0, 3, 0);
    do_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'h0,         9, 0, 32'h0,        1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 32'h0,        1'b0, 3'd1, 1, 0);
    do_op("lw_err", 1'b1, 1'b0, 3'b010, 32'h8000_0008, 32'h0,         3, 3, 32'h1111_2222, 1'b1, 1'b1, 32'h0,        4'b0000, 1'b0, 32'h0,        1'b0, 3'd3, 6, 2);
    do_op("alu_r0", 1'b0, 1'b0, 3'b000, 32'h0,         32'h0000_1234, 0, 0, 32'h0,        1'b0, 1'b0, 32'h0,        4'b0000, 1'b1, 32'h0000_1234, 1'b0, 3'd0, 1, 0);
    do_op("lh",     1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0,         1, 0, 32'h8001_0000, 1'b0, 1'b1, 32'h0,        4'b0000, 1'b1, 32'hFFFF_8001, 1'b1, 3'd0, 3, 0);
    do_op("sw_ill", 1'b0, 1'b1, 3'b011, 32'h8000_0000, 32'h5555_5555, 2, 0, 32'h0,        1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 32'h0,        1'b0, 3'd5, 1, 0);
    do_op("sb_err", 1'b0, 1'b1, 3'b000, 32'h8000_0001, 32'h0000_00AB, 6, 1, 32'h0,        1'b1, 1'b1, 32'h0000_AB00, 4'b0010, 1'b0, 32'h0,        1'b0, 3'd4, 4, 0);
    do_op("alu_r4", 1'b0, 1'b0, 3'b000, 32'h0,         32'hCAFE_0000, 4, 0, 32'h0,        1'b0, 1'b0, 32'h0,        4'b0000, 1'b1, 32'hCAFE_0000, 1'b1, 3'd0, 1, 0);

    // Reset while a load waits in RESP.
    @(negedge clk);
    in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0; in_funct3 = 3'b010;
    in_addr = 32'h8000_0010; in_rd = 5'd2;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("rstmid.req_valid_pre", 32'(req_valid), 32'd1);
    req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_ready = 1'b0;
    check("rstmid.rsp_ready_pre", 32'(rsp_ready), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid.req_valid", 32'(req_valid), 32'd0);
    check("rstmid.out_valid", 32'(out_valid), 32'd0);
    check("rstmid.in_ready", 32'(in_ready), 32'd1);
    check("rstmid.rsp_ready", 32'(rsp_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("post_rst", 1'b0, 1'b0, 3'b000, 32'h0, 32'h0000_0042, 8, 0, 32'h0, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b1, 32'h0000_0042, 1'b1, 3'd0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
